branch_predictor_param: RTL

- Parametrised direction predictor for the lab4 fetch stage; successor to the fixed 2-bit global-history predictor.
- Holds a pattern history table (PHT) of N-bit saturating counters and a global history register (GHR).
- Selectable index mode: bimodal, global, or gshare.
- Gives a same-cycle taken/not-taken prediction, accepts one resolved-branch update per cycle, and keeps misprediction statistics.

---
 rtl/lab4_branch_pkg.sv | 23 ++
 rtl/lab4_branch_sat_pht.sv | 50 +++++
 rtl/branch_predictor_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/lab4_branch_pkg.sv
// lab4 direction predictor: shared types and
// sizing helpers.
package lab4_branch_pkg;

  typedef enum logic [1:0] {
    BP_BIMODAL = 2'd0,
    BP_GLOBAL  = 2'd1,
    BP_GSHARE  = 2'd2
  } bp_mode_e;

  function automatic int ctr_init(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int ctr_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  function automatic int idx_width(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/lab4_branch_sat_pht.sv
// lab4 pattern history table: saturating
// counters, async init, read-before-write.
module lab4_branch_sat_pht
  import lab4_branch_pkg::*;
#(
  parameter int PHT_SIZE = 2048,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = idx_width(PHT_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_taken,
  output logic [CTR_BITS-1:0] old_ctr
);

  localparam logic [CTR_BITS-1:0] INIT =
    CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] MAX =
    CTR_BITS'(ctr_max(CTR_BITS));

  logic [CTR_BITS-1:0] pht [PHT_SIZE];
  logic [CTR_BITS-1:0] new_ctr;

  assign rd_ctr  = pht[rd_idx];
  assign old_ctr = pht[wr_idx];

  // saturating step toward the resolved outcome
  always_comb begin
    new_ctr = old_ctr;
    if (wr_taken && old_ctr != MAX)
      new_ctr = old_ctr + 1'b1;
    else if (!wr_taken && old_ctr != '0)
      new_ctr = old_ctr - 1'b1;
  end

  // table storage, every entry weakly not-taken on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_SIZE; i++)
        pht[i] <= INIT;
    end else if (wr_en) begin
      pht[wr_idx] <= new_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor_param.sv
// lab4 parametrised direction predictor:
// GHR, index select and statistics.
module branch_predictor_param
  import lab4_branch_pkg::*;
#(
  parameter int PHT_SIZE = 2048,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 11,
  parameter int MODE     = 2,
  parameter int PC_LSB   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_val,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        hist_clear,
  output logic [31:0] num_updates,
  output logic [31:0] num_mispred
);

  localparam int IDX_W = idx_width(PHT_SIZE);
  localparam bp_mode_e MODE_E =
    bp_mode_e'(MODE[1:0]);

  if (PHT_SIZE < 16 || PHT_SIZE > 4096 ||
      (PHT_SIZE & (PHT_SIZE - 1)) != 0) begin : g_bad_size
    $error("PHT_SIZE must be a power of two in 16..4096");
  end
  if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr
    $error("CTR_BITS must be in 1..4");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_bad_ghr
    $error("GHR_BITS must be in 1..IDX_W");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("MODE must be 0, 1 or 2");
  end
  if (PC_LSB < 0 || PC_LSB + IDX_W > 32) begin : g_bad_lsb
    $error("PC_LSB + IDX_W must fit in 32 bits");
  end

  logic [GHR_BITS-1:0] ghr;
  logic [GHR_BITS:0]   ghr_sh;
  logic [IDX_W-1:0]    hist;
  logic [IDX_W-1:0]    pred_idx;
  logic [IDX_W-1:0]    upd_idx;
  logic [CTR_BITS-1:0] rd_ctr;
  logic [CTR_BITS-1:0] old_ctr;
  logic                mispred;
  logic                unused_ok;

  assign hist   = IDX_W'(ghr);
  assign ghr_sh = {ghr, update_taken};

  function automatic logic [IDX_W-1:0] mk_idx(
    input logic [31:0]      pc,
    input logic [IDX_W-1:0] h
  );
    logic [IDX_W-1:0] p;
    logic [IDX_W-1:0] idx;
    p = pc[PC_LSB +: IDX_W];
    unique case (1'b1)
      (MODE_E == BP_BIMODAL): idx = p;
      (MODE_E == BP_GLOBAL):  idx = h;
      default:                idx = p ^ h;
    endcase
    return idx;
  endfunction

  assign pred_idx = mk_idx(pred_pc, hist);
  assign upd_idx  = mk_idx(update_pc, hist);

  lab4_branch_sat_pht #(
    .PHT_SIZE (PHT_SIZE),
    .CTR_BITS (CTR_BITS),
    .IDX_W    (IDX_W)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pred_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (update_en),
    .wr_idx   (upd_idx),
    .wr_taken (update_taken),
    .old_ctr  (old_ctr)
  );

  assign pred_taken = pred_val & rd_ctr[CTR_BITS-1];
  assign mispred    = old_ctr[CTR_BITS-1] != update_taken;
  assign unused_ok  = ^{pred_pc, update_pc, ghr_sh[GHR_BITS]};

  // history shift; a clear wins over a concurrent shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ghr <= '0;
    else if (hist_clear)
      ghr <= '0;
    else if (update_en)
      ghr <= ghr_sh[GHR_BITS-1:0];
  end

  // saturating update and misprediction counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_updates <= '0;
      num_mispred <= '0;
    end else if (update_en) begin
      if (num_updates != '1)
        num_updates <= num_updates + 32'd1;
      if (mispred && num_mispred != '1)
        num_mispred <= num_mispred + 32'd1;
    end
  end

endmodule
